// File: rtl/enc_input_key.sv
// Transmit side of the serial key/mode command interface: on Start, shifts a
// fixed unlock key out MSB first on InputKey (strobed by ValidCmd), then one mode bit.
module enc_input_key #(
   parameter int unsigned        KEY_LEN = 4,
   parameter logic [KEY_LEN-1:0] KEY     = 4'b1010,
   parameter int unsigned        BIT_GAP = 0
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Start,
   input  logic ModeReq,
   input  logic Abort,
   output logic InputKey,
   output logic ValidCmd,
   output logic Busy,
   output logic Done
);

   // Key widened to 16 bits so the 4-bit index addresses it at full width.
   localparam logic [15:0] KEY_EXT  = 16'(KEY);
   localparam logic [3:0]  IDX_INIT = 4'(KEY_LEN - 1);
   localparam logic [3:0]  GAP_INIT = 4'(BIT_GAP - 1);
   localparam bit          HAS_GAP  = (BIT_GAP != 0);

   typedef enum logic [4:0] {
      S_IDLE = 5'b00001,
      S_KEY  = 5'b00010,
      S_GAP  = 5'b00100,
      S_MODE = 5'b01000,
      S_DONE = 5'b10000
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic [3:0] gap_q, gap_d;
   logic       last_q, last_d;
   logic       mode_q, mode_d;
   logic       key_q, key_d;
   logic       valid_q, valid_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      last_d  = last_q;
      mode_d  = mode_q;

      case (state_q)
         S_IDLE: begin
            if (Start) begin
               mode_d  = ModeReq;
               idx_d   = IDX_INIT;
               gap_d   = '0;
               last_d  = 1'b0;
               state_d = S_KEY;
            end
         end
         S_KEY: begin
            // last_q remembers that the final key bit went out, so a trailing gap leads to MODE.
            if (idx_q == '0) begin
               last_d = 1'b1;
            end else begin
               idx_d = idx_q - 4'd1;
            end
            if (HAS_GAP) begin
               gap_d   = GAP_INIT;
               state_d = S_GAP;
            end else if (idx_q == '0) begin
               state_d = S_MODE;
            end
         end
         S_GAP: begin
            if (gap_q == '0) begin
               state_d = last_q ? S_MODE : S_KEY;
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end
         S_MODE: state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (Abort && (state_q inside {S_KEY, S_GAP, S_MODE})) begin
         state_d = S_IDLE;
         idx_d   = '0;
         gap_d   = '0;
         last_d  = 1'b0;
      end
   end

   // Outputs are decoded from the next state and registered, so they line up with the state.
   always_comb begin
      valid_d = (state_d == S_KEY) || (state_d == S_MODE);
      key_d   = 1'b0;
      if (state_d == S_KEY) begin
         key_d = KEY_EXT[idx_d];
      end else if (state_d == S_MODE) begin
         key_d = mode_d;
      end
      busy_d = state_d inside {S_KEY, S_GAP, S_MODE};
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         gap_q   <= '0;
         last_q  <= 1'b0;
         mode_q  <= 1'b0;
         key_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         last_q  <= last_d;
         mode_q  <= mode_d;
         key_q   <= key_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign InputKey = key_q;
   assign ValidCmd = valid_q;
   assign Busy     = busy_q;
   assign Done     = done_q;

endmodule

// File: tb/tb_enc_input_key.sv
// Directed bench for enc_input_key: default build (no gap) and a BIT_GAP=2 build.
module tb_enc_input_key;

   logic Clk = 1'b0;
   logic Reset;
   logic a_start, a_mode, a_abort;
   logic a_key, a_valid, a_busy, a_done;
   logic b_start, b_mode, b_abort;
   logic b_key, b_valid, b_busy, b_done;

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   enc_input_key #(.KEY_LEN(4), .KEY(4'b1010), .BIT_GAP(0)) u_dut (
      .Clk(Clk), .Reset(Reset), .Start(a_start), .ModeReq(a_mode), .Abort(a_abort),
      .InputKey(a_key), .ValidCmd(a_valid), .Busy(a_busy), .Done(a_done)
   );

   enc_input_key #(.KEY_LEN(4), .KEY(4'b1010), .BIT_GAP(2)) u_dut_gap (
      .Clk(Clk), .Reset(Reset), .Start(b_start), .ModeReq(b_mode), .Abort(b_abort),
      .InputKey(b_key), .ValidCmd(b_valid), .Busy(b_busy), .Done(b_done)
   );

   // Observed vectors are {ValidCmd, InputKey, Busy, Done}.
   task automatic test_reset();
      logic [3:0] got;
      Reset = 1'b0; a_start = 1'b1; b_start = 1'b1; a_mode = 1'b1; b_mode = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge Clk);
         got = {a_valid, a_key, a_busy, a_done};
         total++;
         if (got !== 4'b0000) begin bad++; $display("FAIL reset_a c=%0d: got %b want 0000", c, got); end
         got = {b_valid, b_key, b_busy, b_done};
         total++;
         if (got !== 4'b0000) begin bad++; $display("FAIL reset_b c=%0d: got %b want 0000", c, got); end
      end
      a_start = 1'b0; b_start = 1'b0; Reset = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge Clk);
         total++;
         if ({a_valid, b_valid} !== 2'b00) begin
            bad++; $display("FAIL idle_valid c=%0d: got %b want 00", c, {a_valid, b_valid});
         end
      end
   endtask

   task automatic test_frame(input logic m);
      logic [4:0] bits;
      logic [4:0] dec;
      logic [3:0] got, exp;
      int         cnt;
      bits = {4'b1010, m};
      dec  = '0;
      cnt  = 0;
      a_start = 1'b1; a_mode = m;
      for (int c = 1; c <= 7; c++) begin
         @(negedge Clk);
         if (c == 1) begin a_start = 1'b0; a_mode = ~m; end
         got = {a_valid, a_key, a_busy, a_done};
         if (c <= 5)       exp = {1'b1, bits[5-c], 1'b1, 1'b0};
         else if (c == 6)  exp = 4'b0001;
         else              exp = 4'b0000;
         total++;
         if (got !== exp) begin bad++; $display("FAIL frame m=%0d c=%0d: got %b want %b", m, c, got, exp); end
         if (a_valid) begin dec = {dec[3:0], a_key}; cnt++; end
      end
      total++;
      if ({(cnt == 5) && (dec[4:1] == 4'b1010), dec[0]} !== {1'b1, m}) begin
         bad++;
         $display("FAIL decoder m=%0d: got active/mode %b%b want 1%b", m,
                  (cnt == 5) && (dec[4:1] == 4'b1010), dec[0], m);
      end
   endtask

   task automatic test_bit_gap();
      logic [4:0] bits;
      logic [3:0] got, exp;
      int         k;
      bits = 5'b10101;
      b_start = 1'b1; b_mode = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         @(negedge Clk);
         if (c == 1) b_start = 1'b0;
         got = {b_valid, b_key, b_busy, b_done};
         k = (c - 1) / 3;
         if (c <= 13 && ((c - 1) % 3) == 0) exp = {1'b1, bits[4-k], 1'b1, 1'b0};
         else if (c <= 13)                  exp = 4'b0010;
         else if (c == 14)                  exp = 4'b0001;
         else                               exp = 4'b0000;
         total++;
         if (got !== exp) begin bad++; $display("FAIL gap c=%0d: got %b want %b", c, got, exp); end
      end
   endtask

   task automatic test_start_ignore();
      logic [4:0] bits;
      logic [3:0] got, exp;
      bits = 5'b10101;
      a_start = 1'b1; a_mode = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         @(negedge Clk);
         got = {a_valid, a_key, a_busy, a_done};
         exp = 4'b0000;
         if (c >= 1 && c <= 5)       exp = {1'b1, bits[5-c], 1'b1, 1'b0};
         else if (c == 6)            exp = 4'b0001;
         else if (c >= 8 && c <= 12) exp = {1'b1, bits[12-c], 1'b1, 1'b0};
         else if (c == 13)           exp = 4'b0001;
         total++;
         if (got !== exp) begin bad++; $display("FAIL restart c=%0d: got %b want %b", c, got, exp); end
         a_start = (c == 2) || (c == 6) || (c == 7);
      end
   endtask

   task automatic test_abort();
      logic [3:0] got, exp;
      a_start = 1'b1; a_mode = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge Clk);
         a_start = 1'b0;
         got = {a_valid, a_key, a_busy, a_done};
         if (c == 1 || c == 3) exp = 4'b1110;
         else if (c == 2)      exp = 4'b1010;
         else                  exp = 4'b0000;
         total++;
         if (got !== exp) begin bad++; $display("FAIL abort c=%0d: got %b want %b", c, got, exp); end
         a_abort = (c == 3);
      end
   endtask

   task automatic test_abort_start();
      logic [3:0] got;
      a_start = 1'b1; a_abort = 1'b1; a_mode = 1'b0;
      @(negedge Clk);
      a_start = 1'b0; a_abort = 1'b0;
      got = {a_valid, a_key, a_busy, a_done};
      total++;
      if (got !== 4'b1110) begin bad++; $display("FAIL abort_start: got %b want 1110", got); end
      for (int c = 2; c <= 7; c++) @(negedge Clk);
      got = {a_valid, a_key, a_busy, a_done};
      total++;
      if (got !== 4'b0000) begin bad++; $display("FAIL abort_start_end: got %b want 0000", got); end
   endtask

   task automatic test_reset_mid();
      logic [3:0] got;
      a_start = 1'b1; a_mode = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge Clk);
         a_start = 1'b0;
      end
      Reset = 1'b0;
      #1;
      got = {a_valid, a_key, a_busy, a_done};
      total++;
      if (got !== 4'b0000) begin bad++; $display("FAIL reset_mid: got %b want 0000", got); end
      @(negedge Clk);
      Reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge Clk);
         got = {a_valid, a_key, a_busy, a_done};
         total++;
         if (got !== 4'b0000) begin bad++; $display("FAIL reset_release c=%0d: got %b want 0000", c, got); end
      end
      test_frame(1'b1);
   endtask

   initial begin
      Reset = 1'b0;
      a_start = 1'b0; a_mode = 1'b0; a_abort = 1'b0;
      b_start = 1'b0; b_mode = 1'b0; b_abort = 1'b0;
      test_reset();
      test_frame(1'b1);
      test_frame(1'b0);
      test_bit_gap();
      test_start_ignore();
      @(negedge Clk);
      test_abort();
      test_abort_start();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/enc_input_key.md
Name: enc_input_key

Overview:
- Transmit side of the serial key/mode command interface.
- On a Start request, serialises a fixed unlock key, MSB first, onto InputKey, each bit qualified by a one-cycle ValidCmd strobe.
- Follows the key with one mode bit, then returns to idle.
- Sits between the control/host logic and the key decoder; its InputKey/ValidCmd outputs connect directly to the decoder inputs of the same names.

Parameters:
- KEY_LEN, 4, number of key bits sent before the mode bit (1..16).
- KEY, 4'b1010, key pattern, KEY_LEN bits wide, sent bit KEY_LEN-1 first.
- BIT_GAP, 0, idle cycles (ValidCmd=0) inserted between consecutive strobes (0..15). 0 = strobes on back-to-back cycles; the decoder requires 0.

Ports:
- Clk  input  1  system clock, all state on rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- Start  input  1  request to send one key+mode frame; sampled only in IDLE.
- ModeReq  input  1  mode bit to send; captured on the cycle Start is accepted.
- Abort  input  1  synchronous cancel of a frame in progress.
- InputKey  output  1  serial data bit, valid while ValidCmd=1.
- ValidCmd  output  1  one-cycle strobe qualifying InputKey.
- Busy  output  1  high from Start acceptance until the frame ends or aborts.
- Done  output  1  one-cycle pulse after the mode bit has been strobed.

Behaviour:
- Reset (Reset=0, asynchronous): InputKey=0, ValidCmd=0, Busy=0, Done=0; state=IDLE; bit counter=0; gap counter=0; mode register=0.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, KEY, GAP, MODE, DONE. One-hot encoding, 5 bits.
- IDLE:
  - Start=1 at an edge -> capture ModeReq and load bit index=KEY_LEN-1.
  - Go to KEY, with Busy=1 from the next cycle.
- KEY:
  - Each cycle in KEY drives ValidCmd=1 and InputKey=KEY[index], then decrements index.
  - Next state after a strobe:
    - index reaches 0 -> MODE, or GAP if BIT_GAP>0.
    - otherwise -> next KEY bit, or GAP if BIT_GAP>0.
- GAP:
  - ValidCmd=0, InputKey=0 for exactly BIT_GAP cycles.
  - Then resume KEY, or go to MODE when all key bits are sent.
- MODE: one cycle with ValidCmd=1, InputKey=captured mode bit; then DONE.
- DONE: Done=1 and Busy=0 for one cycle; ValidCmd=0; then IDLE.
- Latency, BIT_GAP=0:
  - Start accepted at edge N.
  - First strobe visible in cycle N+1.
  - Key strobes occupy N+1..N+KEY_LEN; the mode strobe is N+KEY_LEN+1.
  - Done in N+KEY_LEN+2.
  - A frame is KEY_LEN+2 cycles, IDLE to IDLE.
- Latency, general: frame length = KEY_LEN+2+KEY_LEN*BIT_GAP cycles.
- ValidCmd is never high outside KEY/MODE.
- InputKey is forced to 0 whenever ValidCmd=0.
- Start while Busy=1 is ignored, not queued. ModeReq changes after capture have no effect.
- Start asserted in the DONE cycle is ignored; a new frame can start at the first IDLE cycle.
- Abort=1 in KEY/GAP/MODE:
  - Next cycle: IDLE, ValidCmd=0, Busy=0, no Done pulse.
  - Abort in IDLE or DONE has no effect.
  - Abort and Start in the same IDLE cycle: Start wins.
- Reset asserted mid-frame: immediate return to reset values; no partial strobe is completed after release.
- Reset release: first state change occurs no earlier than the first Clk edge with Reset=1.

Test Plan:
- Reset=0 for 3 cycles with Start=1 -> all outputs 0. Release, no Start -> ValidCmd stays 0 for 20 cycles.
- Defaults, Start=1 with ModeReq=1 for one cycle -> ValidCmd=1 for 5 consecutive cycles, InputKey=1,0,1,0,1. Done pulse on the 6th cycle. Busy high for cycles 1-5.
- Same with ModeReq=0 -> InputKey=1,0,1,0,0. Decoder model connected -> Active=1, Mode=0.
- BIT_GAP=2, KEY=4'b1010, ModeReq=1 -> strobes at cycles 1, 4, 7, 10, 13. Done at cycle 14. ValidCmd=0 and InputKey=0 in all gap cycles.
- Start re-pulsed at cycles 2 and 6 (DONE cycle) -> ignored; a single frame is sent. Start at cycle 7 -> second frame begins at cycle 8.
- Abort=1 at cycle 3 -> ValidCmd=0 and Busy=0 from cycle 4, no Done. Separately, Reset=0 at cycle 3 -> all outputs 0 immediately; the next Start produces a full 5-strobe frame.
